// File: rtl/sirv_gnrl_lden_arb_pkg.sv
// Shared definitions for the locking round-robin arbiter.
// Holds the state encoding and the requester-count/id-width relation.
package sirv_gnrl_lden_arb_pkg;

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } arb_st_e;

    localparam int ARB_N_DEF  = 4;
    localparam int ARB_DW_DEF = 32;
    localparam int ARB_N_MIN  = 2;
    localparam int ARB_N_MAX  = 8;

    function automatic int arb_idw(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/sirv_gnrl_dfflr.sv
// Load-enabled flop bank with asynchronous active-low clear.
// Used for every piece of state in the arbiter.
module sirv_gnrl_dfflr #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          lden_i,
    input  logic [DW-1:0] dnxt_i,
    output logic [DW-1:0] qout_o
);

    logic [DW-1:0] qout_q;

    // capture next value only when enabled; clear at once on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qout_q <= '0;
        end else if (lden_i) begin
            qout_q <= dnxt_i;
        end
    end

    assign qout_o = qout_q;

endmodule

// File: rtl/sirv_gnrl_lden_arb.sv
// Round-robin arbiter that locks onto a requester for a whole burst
// and feeds a single-entry output buffer loaded on each accepted beat.
module sirv_gnrl_lden_arb
    import sirv_gnrl_lden_arb_pkg::*;
#(
    parameter int N   = ARB_N_DEF,
    parameter int DW  = ARB_DW_DEF,
    parameter int IDW = arb_idw(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_vld,
    input  logic [N-1:0]    req_last,
    input  logic [N*DW-1:0] req_dat,
    output logic [N-1:0]    req_rdy,
    output logic            o_vld,
    input  logic            o_rdy,
    output logic [DW-1:0]   o_dat,
    output logic [IDW-1:0]  o_id,
    output logic            o_last
);

    // first valid requester at or after ptr, wrapping around
    function automatic logic [IDW-1:0] rr_pick(
        input logic [N-1:0]   vld,
        input logic [IDW-1:0] ptr
    );
        logic [IDW-1:0] sel;
        logic           hit;
        int             idx;
        sel = '0;
        hit = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!hit && vld[idx]) begin
                sel = IDW'(idx);
                hit = 1'b1;
            end
        end
        return sel;
    endfunction

    logic [0:0]     state_raw;
    arb_st_e        state_q;
    arb_st_e        state_d;
    logic [IDW-1:0] rr_ptr_q;
    logic [IDW-1:0] rr_ptr_d;
    logic [IDW-1:0] lock_id_q;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] owner;
    logic [N-1:0]   rdy_d;
    logic           any_vld;
    logic           can_load;
    logic           lden;
    logic           own_last;
    logic           vld_lden;
    logic [DW-1:0]  own_dat;

    assign state_q  = arb_st_e'(state_raw);
    assign any_vld  = |req_vld;
    assign can_load = ~o_vld | o_rdy;
    assign winner   = rr_pick(req_vld, rr_ptr_q);

    // grant decode: locked owner only, or round-robin winner
    always_comb begin
        rdy_d = '0;
        owner = winner;
        unique case (state_q)
            ST_LOCK: begin
                owner            = lock_id_q;
                rdy_d[lock_id_q] = can_load;
            end
            ST_ARB: begin
                if (any_vld) begin
                    rdy_d[winner] = can_load;
                end
            end
            default: begin
                rdy_d = '0;
            end
        endcase
    end

    assign req_rdy  = rdy_d;
    assign lden     = |(req_vld & rdy_d);
    assign own_last = req_last[owner];
    assign own_dat  = req_dat[int'(owner)*DW +: DW];
    assign vld_lden = lden | (o_vld & o_rdy);

    // next state and pointer derived from the transferring beat
    always_comb begin
        state_d  = own_last ? ST_ARB : ST_LOCK;
        rr_ptr_d = (owner == IDW'(N - 1)) ? '0 : owner + IDW'(1);
    end

    sirv_gnrl_dfflr #(.DW(1)) u_state (
        .clk    (clk),
        .rst_n  (rst_n),
        .lden_i (lden),
        .dnxt_i (state_d),
        .qout_o (state_raw)
    );

    sirv_gnrl_dfflr #(.DW(IDW)) u_lock_id (
        .clk    (clk),
        .rst_n  (rst_n),
        .lden_i (lden),
        .dnxt_i (owner),
        .qout_o (lock_id_q)
    );

    sirv_gnrl_dfflr #(.DW(IDW)) u_rr_ptr (
        .clk    (clk),
        .rst_n  (rst_n),
        .lden_i (lden & own_last),
        .dnxt_i (rr_ptr_d),
        .qout_o (rr_ptr_q)
    );

    sirv_gnrl_dfflr #(.DW(1)) u_o_vld (
        .clk    (clk),
        .rst_n  (rst_n),
        .lden_i (vld_lden),
        .dnxt_i (lden),
        .qout_o (o_vld)
    );

    sirv_gnrl_dfflr #(.DW(DW)) u_o_dat (
        .clk    (clk),
        .rst_n  (rst_n),
        .lden_i (lden),
        .dnxt_i (own_dat),
        .qout_o (o_dat)
    );

    sirv_gnrl_dfflr #(.DW(IDW)) u_o_id (
        .clk    (clk),
        .rst_n  (rst_n),
        .lden_i (lden),
        .dnxt_i (owner),
        .qout_o (o_id)
    );

    sirv_gnrl_dfflr #(.DW(1)) u_o_last (
        .clk    (clk),
        .rst_n  (rst_n),
        .lden_i (lden),
        .dnxt_i (own_last),
        .qout_o (o_last)
    );

endmodule

// File: tb/tb_sirv_gnrl_lden_arb.sv
// Scripted bench for the locking round-robin arbiter.
// Expected beats are queued on grant and checked when they drain.
module tb_sirv_gnrl_lden_arb;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int IDW = 2;

    typedef struct {
        logic [IDW-1:0] id;
        logic [DW-1:0]  dat;
        logic           last;
    } beat_t;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_vld;
    logic [N-1:0]    req_last;
    logic [N*DW-1:0] req_dat;
    logic [N-1:0]    req_rdy;
    logic            o_vld;
    logic            o_rdy;
    logic [DW-1:0]   o_dat;
    logic [IDW-1:0]  o_id;
    logic            o_last;

    beat_t sb_q[$];
    int    n_vec;
    int    n_err;
    int    stamp;
    logic  exp_ovld;

    sirv_gnrl_lden_arb #(.N(N), .DW(DW), .IDW(IDW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_vld  (req_vld),
        .req_last (req_last),
        .req_dat  (req_dat),
        .req_rdy  (req_rdy),
        .o_vld    (o_vld),
        .o_rdy    (o_rdy),
        .o_dat    (o_dat),
        .o_id     (o_id),
        .o_last   (o_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // one cycle: drive at negedge, check grants and buffered beat
    task automatic cyc(input logic [N-1:0] vld, input logic [N-1:0] last,
                       input logic ordy, input logic [N-1:0] exp_rdy);
        beat_t b;
        logic  xfer;
        @(negedge clk);
        stamp++;
        req_vld  = vld;
        req_last = last;
        o_rdy    = ordy;
        for (int i = 0; i < N; i++)
            req_dat[i*DW +: DW] = {4'(i), 4'hA, 24'(stamp)};
        #1;
        chk("req_rdy", 64'(req_rdy), 64'(exp_rdy));
        chk("o_vld", 64'(o_vld), 64'(exp_ovld));
        if (exp_ovld) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_underflow: got empty want beat");
            end else begin
                chk("o_id", 64'(o_id), 64'(sb_q[0].id));
                chk("o_dat", 64'(o_dat), 64'(sb_q[0].dat));
                chk("o_last", 64'(o_last), 64'(sb_q[0].last));
                if (ordy) void'(sb_q.pop_front());
            end
        end
        xfer = |(vld & exp_rdy);
        if (xfer) begin
            b.id = '0;
            for (int i = 0; i < N; i++)
                if (exp_rdy[i]) b.id = IDW'(i);
            b.dat  = {4'(b.id), 4'hA, 24'(stamp)};
            b.last = last[b.id];
            sb_q.push_back(b);
        end
        exp_ovld = xfer | (exp_ovld & ~ordy);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        stamp    = 0;
        exp_ovld = 1'b0;
        rst_n    = 1'b0;
        req_vld  = '0;
        req_last = '0;
        req_dat  = '0;
        o_rdy    = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_o_vld", 64'(o_vld), 64'd0);
        chk("rst_o_dat", 64'(o_dat), 64'd0);
        chk("rst_o_id", 64'(o_id), 64'd0);
        chk("rst_o_last", 64'(o_last), 64'd0);
        rst_n = 1'b1;

        // all requesters, single-beat bursts: rotate 0,1,2,3,0
        cyc(4'b1111, 4'b1111, 1'b1, 4'b0001);
        cyc(4'b1111, 4'b1111, 1'b1, 4'b0010);
        cyc(4'b1111, 4'b1111, 1'b1, 4'b0100);
        cyc(4'b1111, 4'b1111, 1'b1, 4'b1000);
        cyc(4'b1111, 4'b1111, 1'b1, 4'b0001);
        cyc(4'b1111, 4'b1111, 1'b1, 4'b0010);

        // requester 2 holds a 3-beat burst, then 3 is next
        cyc(4'b1111, 4'b1011, 1'b1, 4'b0100);
        cyc(4'b1111, 4'b1011, 1'b1, 4'b0100);
        cyc(4'b1111, 4'b1111, 1'b1, 4'b0100);
        cyc(4'b1111, 4'b1111, 1'b1, 4'b1000);

        // owner 0 drops valid mid-burst: nobody else is granted
        cyc(4'b1111, 4'b1110, 1'b1, 4'b0001);
        cyc(4'b1110, 4'b1110, 1'b1, 4'b0001);
        cyc(4'b1110, 4'b1110, 1'b1, 4'b0001);
        cyc(4'b1111, 4'b1111, 1'b1, 4'b0001);

        // downstream stall: no grants, buffer stable, then drain+reload
        repeat (5) cyc(4'b1111, 4'b1111, 1'b0, 4'b0000);
        cyc(4'b1111, 4'b1111, 1'b1, 4'b0010);
        cyc(4'b0000, 4'b0000, 1'b1, 4'b0000);
        cyc(4'b0000, 4'b0000, 1'b1, 4'b0000);

        // lone requester 1 streams one beat per cycle
        repeat (6) cyc(4'b0010, 4'b1111, 1'b1, 4'b0010);

        // open a burst on requester 2, then reset in the middle
        cyc(4'b1111, 4'b0000, 1'b1, 4'b0100);
        @(negedge clk);
        rst_n   = 1'b0;
        req_vld = '0;
        #1;
        chk("midrst_o_vld", 64'(o_vld), 64'd0);
        chk("midrst_o_id", 64'(o_id), 64'd0);
        sb_q.delete();
        exp_ovld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // post-reset search restarts at requester 0
        cyc(4'b1010, 4'b1111, 1'b1, 4'b0010);
        cyc(4'b1010, 4'b1111, 1'b1, 4'b1000);
        cyc(4'b0000, 4'b0000, 1'b1, 4'b0000);
        cyc(4'b0000, 4'b0000, 1'b1, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sirv_gnrl_lden_arb.md
SIRV_GNRL_LDEN_ARB -- requirements
Module: sirv_gnrl_lden_arb

Interface
REQ-001 Parameter N, default 4, number of requesters (2..8).
REQ-002 Parameter DW, default 32, payload width.
REQ-003 Parameter IDW, default 2, requester-id width; SHALL equal ceil(log2(N)).
REQ-004 clk  input  1  clock, all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req_vld  input  N  per-requester valid.
REQ-007 req_last  input  N  per-requester last beat of burst.
REQ-008 req_dat  input  N*DW  payloads, requester i at bits [i*DW +: DW].
REQ-009 req_rdy  output  N  per-requester ready, one-hot or zero.
REQ-010 o_vld  output  1  buffered beat valid.
REQ-011 o_rdy  input  1  downstream ready.
REQ-012 o_dat  output  DW  buffered payload.
REQ-013 o_id  output  IDW  requester index of buffered beat.
REQ-014 o_last  output  1  buffered beat is burst end.

Function
REQ-015 Beat transfer on requester side: req_vld[i] & req_rdy[i] in the same cycle; on output side: o_vld & o_rdy.
REQ-016 Single-entry output buffer; can_load = ~o_vld | o_rdy; the buffer loads (lden=1) exactly when a requester transfer occurs.
REQ-017 Latency: a beat accepted in cycle T appears on o_vld/o_dat/o_id/o_last in cycle T+1; full throughput of one beat/cycle when o_rdy stays 1.
REQ-018 When o_vld=1, o_rdy=0 and no load occurs, o_dat/o_id/o_last SHALL hold stable.
REQ-019 FSM states: ARB (no burst open) and LOCK (burst open, owner register lock_id valid).
REQ-020 ARB: winner = first i with req_vld[i]=1, searching circularly from rr_ptr; req_rdy[winner]=can_load, all others 0.
REQ-021 ARB -> LOCK when winner transfers with req_last=0; lock_id <= winner.
REQ-022 ARB stays in ARB when winner transfers with req_last=1.
REQ-023 LOCK: req_rdy[lock_id]=can_load, all other req_rdy=0 regardless of their req_vld.
REQ-024 LOCK -> ARB when lock_id transfers with req_last=1.
REQ-025 rr_ptr <= (owner+1) mod N on the transfer that closes a burst (req_last=1), in either state; otherwise rr_ptr holds.
REQ-026 No requester valid, or can_load=0: no transfer, no state or pointer change.
REQ-027 Output buffer drain and reload in the same cycle SHALL both take effect (o_vld remains 1, new data).
REQ-028 Output drain with no load: o_vld <= 0 next cycle.
REQ-029 req_rdy SHALL depend combinationally on req_vld, o_vld, o_rdy and state only; it SHALL NOT depend on req_dat.
REQ-030 Requester dropping req_vld mid-burst in LOCK: lock held, no other requester granted.

Reset
REQ-031 On rst_n=0: o_vld=0, o_dat=0, o_id=0, o_last=0, state=ARB, rr_ptr=0, lock_id=0, immediately and asynchronously.
REQ-032 Reset mid-burst SHALL discard the open burst and buffered beat; first post-reset grant starts from requester 0.

Structure
REQ-033 State encoding and N/IDW relation constants SHALL reside in the shared general-purpose package.
REQ-034 All output buffer, rr_ptr, lock_id and state registers SHALL be instances of sirv_gnrl_dfflr driven by the computed lden.
REQ-035 Arbitration priority search SHALL be a single combinational function; no further sub-modules.

Verification
REQ-036 Reset, then req_vld=4'b1111, all req_last=1, o_rdy=1 -> grants 0,1,2,3,0 on consecutive cycles; o_id matches one cycle later.
REQ-037 Requester 2 sends 3-beat burst (last on beat 3) while req_vld=4'b1111 -> req_rdy=4'b0100 for 3 transfers, then next grant requester 3.
REQ-038 o_vld=1, o_rdy=0 for 5 cycles with all requesters valid -> req_rdy=0, o_dat stable; o_rdy=1 -> drain and reload in same cycle.
REQ-039 Single requester 1 continuous, req_last=1, o_rdy=1 -> one beat/cycle, o_dat = input delayed by exactly 1 cycle.
REQ-040 rst_n asserted during LOCK with o_vld=1 -> o_vld=0 at once; after release, req_vld=4'b1010 -> requester 1 granted first.
